// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C engine between two requesters, with locked bursts and a timeout watchdog.
// Define I2C_ARB_FIXED_PRIO_EN to make requester 0 always win ties instead of alternating.
module i2c_bus_arbiter #(
    parameter int TIMEOUT_CYC = 500_000,
    parameter int CNT_W       = 20
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  lock,
    input  logic [1:0]  rw,
    input  logic [13:0] dev_addr,
    input  logic [15:0] reg_addr,
    input  logic [15:0] wdata,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [7:0]  rdata,
    input  logic        eng_ready,
    output logic        eng_start,
    output logic [6:0]  eng_dev,
    output logic [7:0]  eng_reg,
    output logic [7:0]  eng_wdata,
    output logic        eng_rw,
    input  logic        eng_done,
    input  logic        eng_nack,
    input  logic [7:0]  eng_rdata,
    output logic        eng_abort
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    state_t           state_reg, state_next;
    logic             own_reg, own_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [1:0]       done_reg, done_next;
    logic [1:0]       err_reg, err_next;
    logic [7:0]       rdata_reg, rdata_next;
    logic             start_reg, start_next;
    logic             abort_reg, abort_next;
    logic [6:0]       cmd_dev_reg, cmd_dev_next;
    logic [7:0]       cmd_addr_reg, cmd_addr_next;
    logic [7:0]       cmd_wdata_reg, cmd_wdata_next;
    logic             cmd_rw_reg, cmd_rw_next;

    logic       win;
    logic       sel;
    logic [1:0] own_hot;
    logic       timeout;

`ifdef I2C_ARB_FIXED_PRIO_EN
    assign win = ~req[0];
`else
    logic last_reg, last_next;
    // With both requesting, whoever was not served last goes next.
    assign win = (req == 2'b11) ? ~last_reg : ~req[0];
`endif

    assign sel     = (state_reg == IDLE) ? win : own_reg;
    assign own_hot = own_reg ? 2'b10 : 2'b01;
    assign timeout = (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_next     = state_reg;
        own_next       = own_reg;
        cnt_next       = cnt_reg;
        done_next      = 2'b00;
        err_next       = 2'b00;
        rdata_next     = rdata_reg;
        start_next     = 1'b0;
        abort_next     = 1'b0;
        cmd_dev_next   = cmd_dev_reg;
        cmd_addr_next  = cmd_addr_reg;
        cmd_wdata_next = cmd_wdata_reg;
        cmd_rw_next    = cmd_rw_reg;
`ifndef I2C_ARB_FIXED_PRIO_EN
        last_next      = last_reg;
`endif
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (|req) begin
                    own_next   = win;
                    state_next = ISSUE;
`ifndef I2C_ARB_FIXED_PRIO_EN
                    last_next  = win;
`endif
                end
            end
            ISSUE: begin
                cnt_next = '0;
                // The strobe is registered, so it lands in the first WAIT cycle.
                if (eng_ready) begin
                    start_next = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (eng_done) begin
                    done_next  = own_hot;
                    err_next   = eng_nack ? own_hot : 2'b00;
                    rdata_next = eng_rdata;
                    cnt_next   = '0;
                    state_next = lock[own_reg] ? HOLD : IDLE;
                end else if (timeout) begin
                    abort_next = 1'b1;
                    done_next  = own_hot;
                    err_next   = own_hot;
                    rdata_next = 8'h00;
                    state_next = IDLE;
                end
            end
            HOLD: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (req[own_reg])
                    state_next = ISSUE;
                else if (!lock[own_reg] || timeout)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // A command is captured whenever we leave IDLE or HOLD for ISSUE.
        if (state_next == ISSUE && (state_reg == IDLE || state_reg == HOLD)) begin
            cmd_dev_next   = sel ? dev_addr[13:7]  : dev_addr[6:0];
            cmd_addr_next  = sel ? reg_addr[15:8]  : reg_addr[7:0];
            cmd_wdata_next = sel ? wdata[15:8]     : wdata[7:0];
            cmd_rw_next    = sel ? rw[1]           : rw[0];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= IDLE;
            own_reg       <= 1'b0;
            cnt_reg       <= '0;
            done_reg      <= 2'b00;
            err_reg       <= 2'b00;
            rdata_reg     <= 8'h00;
            start_reg     <= 1'b0;
            abort_reg     <= 1'b0;
            cmd_dev_reg   <= 7'h00;
            cmd_addr_reg  <= 8'h00;
            cmd_wdata_reg <= 8'h00;
            cmd_rw_reg    <= 1'b0;
`ifndef I2C_ARB_FIXED_PRIO_EN
            last_reg      <= 1'b1;
`endif
        end else begin
            state_reg     <= state_next;
            own_reg       <= own_next;
            cnt_reg       <= cnt_next;
            done_reg      <= done_next;
            err_reg       <= err_next;
            rdata_reg     <= rdata_next;
            start_reg     <= start_next;
            abort_reg     <= abort_next;
            cmd_dev_reg   <= cmd_dev_next;
            cmd_addr_reg  <= cmd_addr_next;
            cmd_wdata_reg <= cmd_wdata_next;
            cmd_rw_reg    <= cmd_rw_next;
`ifndef I2C_ARB_FIXED_PRIO_EN
            last_reg      <= last_next;
`endif
        end
    end

    assign gnt       = (state_reg == IDLE) ? 2'b00 : own_hot;
    assign done      = done_reg;
    assign err       = err_reg;
    assign rdata     = rdata_reg;
    assign eng_start = start_reg;
    assign eng_abort = abort_reg;
    assign eng_dev   = cmd_dev_reg;
    assign eng_reg   = cmd_addr_reg;
    assign eng_wdata = cmd_wdata_reg;
    assign eng_rw    = cmd_rw_reg;

endmodule
